xfft_seq: RTL and testbench
===========================

Name: xfft_seq

Overview:
- Run-time sequencer for the AXI-Stream xFFT datapath, in the SERIAL_CLK domain.
- Sits between the M2S stream source / S2M stream sink and the xFFT core.
- On START: issues one xFFT config word, then gates NUM_FRAMES frames of P_NFFT samples into the core, generating input TLAST.
- Counts and checks output frames, raises DONE after the last output frame drains, and reports errors.

Parameters:
P_NFFT_LOG2, 10, log2 of FFT points per frame (N = 2**P_NFFT_LOG2)
P_SCALE_W, 10, width of xFFT scaling schedule field
P_CFG_W, 16, config TDATA width; must be >= P_SCALE_W+1

Ports:
SERIAL_CLK  in  1  stream clock
SERIAL_RST  in  1  asynchronous reset, active-high
START  in  1  one-cycle pulse; begins a run from IDLE
ABORT  in  1  one-cycle pulse; cancels run from any state
NUM_FRAMES  in  16  frames per run; sampled at START
CFG_FWD_INV  in  1  1 = forward FFT; sampled at START
CFG_SCALE  in  P_SCALE_W  scaling schedule; sampled at START
CONFIG_TVALID  out  1  xFFT config channel valid
CONFIG_TREADY  in  1  xFFT config channel ready
CONFIG_TDATA  out  P_CFG_W  {zeros, SCALE, FWD_INV}; FWD_INV at bit 0
M2S_TVALID  in  1  source sample valid
M2S_TREADY  out  1  source sample ready
FFT_DIN_TVALID  out  1  core input valid
FFT_DIN_TREADY  in  1  core input ready
FFT_DIN_TLAST  out  1  generated frame end
FFT_DOUT_TVALID  in  1  core output valid
FFT_DOUT_TREADY  out  1  core output ready
FFT_DOUT_TLAST  in  1  core output frame end
S2M_TVALID  out  1  sink valid
S2M_TREADY  in  1  sink ready
S2M_TLAST  out  1  regenerated output frame end
EVENT_TLAST_UNEXPECTED  in  1  xFFT event
EVENT_TLAST_MISSING  in  1  xFFT event
BUSY  out  1  state != IDLE
DONE  out  1  one-cycle pulse at run completion
ERR  out  3  sticky: [0] unexpected, [1] missing, [2] output TLAST mismatch
FRAME_IN_CNT  out  16  input frames accepted in this run
FRAME_OUT_CNT  out  16  output frames delivered in this run

Behaviour:
- Data buses are not routed through this block; only handshakes and TLAST are.
- Reset: state IDLE; all counters 0; ERR 0; every output 0; CONFIG_TDATA 0.
- States: IDLE, CFG, RUN, DRAIN, FIN.
- IDLE
  - START with NUM_FRAMES != 0: latch NUM_FRAMES/CFG_*, clear counters and ERR, go to CFG next cycle.
  - START with NUM_FRAMES == 0: ignored.
- CFG
  - CONFIG_TVALID=1, TDATA stable.
  - On CONFIG_TVALID&CONFIG_TREADY: go to RUN; TVALID drops next cycle.
- RUN (input path)
  - FFT_DIN_TVALID = M2S_TVALID; M2S_TREADY = FFT_DIN_TREADY. Combinational pass; 0 outside RUN.
  - in_cnt (P_NFFT_LOG2 bits) increments per input handshake.
  - FFT_DIN_TLAST = (in_cnt == N-1), combinational.
  - On a TLAST handshake: in_cnt wraps to 0 and FRAME_IN_CNT increments.
  - When FRAME_IN_CNT reaches latched NUM_FRAMES: go to DRAIN; input gated off from the next cycle.
- Output path (CFG, RUN, DRAIN)
  - S2M_TVALID = FFT_DOUT_TVALID; FFT_DOUT_TREADY = S2M_TREADY.
  - out_cnt counts handshakes; S2M_TLAST = (out_cnt == N-1).
  - On a handshake where FFT_DOUT_TLAST != S2M_TLAST: set ERR[2]. S2M_TLAST still follows out_cnt.
  - At out_cnt N-1: wrap and increment FRAME_OUT_CNT.
  - In IDLE/FIN: FFT_DOUT_TREADY=0, S2M_TVALID=0.
- DRAIN
  - Go to FIN when FRAME_OUT_CNT == NUM_FRAMES.
  - This includes the cycle in which the final output handshake occurs: FIN follows on the next edge.
- FIN: DONE=1 for one cycle, then IDLE. FRAME_*_CNT and ERR hold until next START.
- EVENT_* inputs set ERR[0]/ERR[1] in any non-IDLE state; they do not stop the run.
- ABORT has priority over START and over all transitions.
  - Next cycle: IDLE, counters cleared, no DONE. ERR holds.
  - A handshake in the ABORT cycle is still counted before the clear.
- START while BUSY: ignored.
- Counters are 16-bit; NUM_FRAMES=65535 is legal, and no wrap occurs within a run.

Optional Feature:
XFFT_SEQ_TIMEOUT_EN
- Defined:
  - Adds a 24-bit watchdog cleared on any input or output handshake, and on entering CFG/RUN/DRAIN.
  - Counts in CFG/RUN/DRAIN otherwise.
  - At 2**24-1: set ERR bit [3] (ERR widens to 4 bits) and act as ABORT.
- Undefined: no watchdog; ERR is 3 bits.

Test Plan:
- P_NFFT_LOG2=3, NUM_FRAMES=2, both ready always 1, FWD_INV=1, SCALE=0x2AA:
  - CONFIG_TDATA = 0x0555 for one handshake.
  - FFT_DIN_TLAST on handshakes 8 and 16; FRAME_IN_CNT=2.
  - Core returns 16 samples with TLAST at 8/16: DONE pulses once; ERR=0.
- Same run with random TVALID/TREADY stalls (50%) on both sides: same counts; TLAST positions unchanged; no handshake lost.
- Core asserts FFT_DOUT_TLAST on the 5th output sample: ERR[2]=1; S2M_TLAST still on the 8th; run completes with DONE.
- ABORT mid-frame (in_cnt=3, FRAME_IN_CNT=1):
  - Next cycle: BUSY=0, M2S_TREADY=0, counters 0, no DONE.
  - A subsequent START runs cleanly.
- START with NUM_FRAMES=0 → BUSY stays 0.
- START asserted during RUN → ignored; latched NUM_FRAMES unchanged.
- EVENT_TLAST_MISSING pulse during RUN → ERR[1]=1, sticky through FIN; cleared on next START.

Source files
------------

// File: rtl/xfft_seq.sv
// Run-time sequencer for the AXI-Stream xFFT core: config word, gated input frames, output frame checking.
// Optional watchdog under `XFFT_SEQ_TIMEOUT_EN (adds ERR[3]).
//   state   | meaning
//   IDLE    | waiting for START
//   CFG     | presenting the config word
//   RUN     | gating input frames into the core
//   DRAIN   | input done, waiting for the last output frame
//   FIN     | one-cycle DONE, then back to IDLE
module xfft_seq #(
  parameter int P_NFFT_LOG2 = 10,
  parameter int P_SCALE_W   = 10,
  parameter int P_CFG_W     = 16,
`ifdef XFFT_SEQ_TIMEOUT_EN
  localparam int ERR_W = 4
`else
  localparam int ERR_W = 3
`endif
) (
  input  logic                 SERIAL_CLK,
  input  logic                 SERIAL_RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [15:0]          NUM_FRAMES,
  input  logic                 CFG_FWD_INV,
  input  logic [P_SCALE_W-1:0] CFG_SCALE,
  output logic                 CONFIG_TVALID,
  input  logic                 CONFIG_TREADY,
  output logic [P_CFG_W-1:0]   CONFIG_TDATA,
  input  logic                 M2S_TVALID,
  output logic                 M2S_TREADY,
  output logic                 FFT_DIN_TVALID,
  input  logic                 FFT_DIN_TREADY,
  output logic                 FFT_DIN_TLAST,
  input  logic                 FFT_DOUT_TVALID,
  output logic                 FFT_DOUT_TREADY,
  input  logic                 FFT_DOUT_TLAST,
  output logic                 S2M_TVALID,
  input  logic                 S2M_TREADY,
  output logic                 S2M_TLAST,
  input  logic                 EVENT_TLAST_UNEXPECTED,
  input  logic                 EVENT_TLAST_MISSING,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [ERR_W-1:0]     ERR,
  output logic [15:0]          FRAME_IN_CNT,
  output logic [15:0]          FRAME_OUT_CNT
);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_RUN, S_DRAIN, S_FIN} state_t;

  localparam logic [P_NFFT_LOG2-1:0] CNT_LAST = '1;

  state_t                 state_q, state_raw, state_d;
  logic [P_NFFT_LOG2-1:0] in_cnt, out_cnt;
  logic [15:0]            frame_in_cnt, frame_out_cnt, num_frames_q;
  logic [15:0]            frame_in_next, frame_out_next;
  logic [P_CFG_W-1:0]     cfg_q, cfg_d;
  logic [ERR_W-1:0]       err_q;
  logic                   in_en, out_en, in_hs, out_hs, in_last, out_last;
  logic                   in_done, out_done, start_ok, abort_any, timeout;

  always_comb begin
    in_en          = (state_q == S_RUN);
    out_en         = (state_q == S_CFG) || (state_q == S_RUN) || (state_q == S_DRAIN);
    in_last        = (in_cnt == CNT_LAST);
    out_last       = (out_cnt == CNT_LAST);
    M2S_TREADY     = in_en & FFT_DIN_TREADY;
    FFT_DIN_TVALID = in_en & M2S_TVALID;
    FFT_DIN_TLAST  = in_en & in_last;
    S2M_TVALID     = out_en & FFT_DOUT_TVALID;
    FFT_DOUT_TREADY = out_en & S2M_TREADY;
    S2M_TLAST      = out_en & out_last;
    in_hs          = in_en & M2S_TVALID & FFT_DIN_TREADY;
    out_hs         = out_en & FFT_DOUT_TVALID & S2M_TREADY;
    frame_in_next  = frame_in_cnt + 16'd1;
    frame_out_next = frame_out_cnt + 16'd1;
    in_done        = in_hs & in_last & (frame_in_next == num_frames_q);
    // The final output handshake itself may complete the run.
    out_done       = (frame_out_cnt == num_frames_q) |
                     (out_hs & out_last & (frame_out_next == num_frames_q));
    abort_any      = ABORT | timeout;
    start_ok       = (state_q == S_IDLE) & START & (NUM_FRAMES != 16'd0) & ~abort_any;
    cfg_d          = '0;
    cfg_d[P_SCALE_W:1] = CFG_SCALE;
    cfg_d[0]       = CFG_FWD_INV;
  end

  always_ff @(posedge SERIAL_CLK or posedge SERIAL_RST) begin
    if (SERIAL_RST) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_raw     = state_q;
    CONFIG_TVALID = 1'b0;
    BUSY          = 1'b1;
    DONE          = 1'b0;
    case (state_q)
      S_IDLE: begin
        BUSY = 1'b0;
        if (START && NUM_FRAMES != 16'd0) state_raw = S_CFG;
      end
      S_CFG: begin
        CONFIG_TVALID = 1'b1;
        if (CONFIG_TREADY) state_raw = S_RUN;
      end
      S_RUN:   if (in_done) state_raw = S_DRAIN;
      S_DRAIN: if (out_done) state_raw = S_FIN;
      S_FIN: begin
        DONE      = 1'b1;
        state_raw = S_IDLE;
      end
      default: state_raw = S_IDLE;
    endcase
    state_d = abort_any ? S_IDLE : state_raw;
  end

`ifdef XFFT_SEQ_TIMEOUT_EN
  logic [23:0] wdog_q;
  logic        wdog_clr;

  always_comb begin
    wdog_clr = in_hs | out_hs |
               ((state_raw != state_q) &&
                ((state_raw == S_CFG) || (state_raw == S_RUN) || (state_raw == S_DRAIN)));
    timeout  = out_en & (wdog_q == 24'd0) & ~in_hs & ~out_hs;
  end

  // Down-counter from all-ones: terminal count 0 equals 2**24-1 idle cycles.
  always_ff @(posedge SERIAL_CLK or posedge SERIAL_RST) begin
    if (SERIAL_RST)             wdog_q <= '1;
    else if (!out_en || wdog_clr) wdog_q <= '1;
    else if (wdog_q != 24'd0)   wdog_q <= wdog_q - 24'd1;
  end
`else
  always_comb timeout = 1'b0;
`endif

  always_ff @(posedge SERIAL_CLK or posedge SERIAL_RST) begin
    if (SERIAL_RST) begin
      in_cnt        <= '0;
      out_cnt       <= '0;
      frame_in_cnt  <= '0;
      frame_out_cnt <= '0;
      num_frames_q  <= '0;
      cfg_q         <= '0;
      err_q         <= '0;
    end else begin
      if (in_hs) begin
        in_cnt <= in_cnt + 1'b1;
        if (in_last) frame_in_cnt <= frame_in_next;
      end
      if (out_hs) begin
        out_cnt <= out_cnt + 1'b1;
        if (out_last) frame_out_cnt <= frame_out_next;
        if (FFT_DOUT_TLAST != out_last) err_q[2] <= 1'b1;
      end
      if (state_q != S_IDLE) begin
        if (EVENT_TLAST_UNEXPECTED) err_q[0] <= 1'b1;
        if (EVENT_TLAST_MISSING)    err_q[1] <= 1'b1;
      end
`ifdef XFFT_SEQ_TIMEOUT_EN
      if (timeout) err_q[3] <= 1'b1;
`endif
      if (start_ok) begin
        num_frames_q  <= NUM_FRAMES;
        cfg_q         <= cfg_d;
        in_cnt        <= '0;
        out_cnt       <= '0;
        frame_in_cnt  <= '0;
        frame_out_cnt <= '0;
        err_q         <= '0;
      end
      // Abort clears after any same-cycle handshake update; ERR is kept.
      if (abort_any) begin
        in_cnt        <= '0;
        out_cnt       <= '0;
        frame_in_cnt  <= '0;
        frame_out_cnt <= '0;
      end
    end
  end

  assign CONFIG_TDATA  = cfg_q;
  assign ERR           = err_q;
  assign FRAME_IN_CNT  = frame_in_cnt;
  assign FRAME_OUT_CNT = frame_out_cnt;

endmodule

// File: tb/tb_xfft_seq.sv
// Scoreboard bench for xfft_seq with 8-point frames: expected TLAST positions queued at stimulus time.
module tb_xfft_seq;
`ifdef XFFT_SEQ_TIMEOUT_EN
  localparam int ERR_W = 4;
`else
  localparam int ERR_W = 3;
`endif
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort_p;
  logic [15:0] num_frames;
  logic        fwd_inv;
  logic [9:0]  scale;
  logic        config_tvalid, config_tready;
  logic [15:0] config_tdata;
  logic        m2s_tvalid, m2s_tready;
  logic        din_tvalid, din_tready, din_tlast;
  logic        dout_tvalid, dout_tready, dout_tlast;
  logic        s2m_tvalid, s2m_tready, s2m_tlast;
  logic        ev_unexp, ev_miss;
  logic        busy, done;
  logic [ERR_W-1:0] err;
  logic [15:0] frame_in_cnt, frame_out_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  bit in_q[$];
  bit out_q[$];

  always #5 clk = ~clk;

  xfft_seq #(.P_NFFT_LOG2(3), .P_SCALE_W(10), .P_CFG_W(16)) dut (
    .SERIAL_CLK(clk), .SERIAL_RST(rst), .START(start), .ABORT(abort_p),
    .NUM_FRAMES(num_frames), .CFG_FWD_INV(fwd_inv), .CFG_SCALE(scale),
    .CONFIG_TVALID(config_tvalid), .CONFIG_TREADY(config_tready), .CONFIG_TDATA(config_tdata),
    .M2S_TVALID(m2s_tvalid), .M2S_TREADY(m2s_tready),
    .FFT_DIN_TVALID(din_tvalid), .FFT_DIN_TREADY(din_tready), .FFT_DIN_TLAST(din_tlast),
    .FFT_DOUT_TVALID(dout_tvalid), .FFT_DOUT_TREADY(dout_tready), .FFT_DOUT_TLAST(dout_tlast),
    .S2M_TVALID(s2m_tvalid), .S2M_TREADY(s2m_tready), .S2M_TLAST(s2m_tlast),
    .EVENT_TLAST_UNEXPECTED(ev_unexp), .EVENT_TLAST_MISSING(ev_miss),
    .BUSY(busy), .DONE(done), .ERR(err),
    .FRAME_IN_CNT(frame_in_cnt), .FRAME_OUT_CNT(frame_out_cnt)
  );

  task automatic idle_inputs();
    start = 0; abort_p = 0; num_frames = 0; fwd_inv = 0; scale = 0;
    config_tready = 0; m2s_tvalid = 0; din_tready = 0; dout_tvalid = 0;
    dout_tlast = 0; s2m_tready = 0; ev_unexp = 0; ev_miss = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    m2s_tvalid = 1; din_tready = 1; dout_tvalid = 1; s2m_tready = 1; config_tready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({busy, done, config_tvalid, m2s_tready, din_tvalid, din_tlast,
         dout_tready, s2m_tvalid, s2m_tlast} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b required 000000000",
               {busy, done, config_tvalid, m2s_tready, din_tvalid, din_tlast,
                dout_tready, s2m_tvalid, s2m_tlast});
    end
    tests_run++;
    if (err !== '0 || config_tdata !== 16'h0 || frame_in_cnt !== 16'h0 || frame_out_cnt !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_regs: err=%0h tdata=%0h fin=%0d fout=%0d required all 0",
               err, config_tdata, frame_in_cnt, frame_out_cnt);
    end
    idle_inputs();
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
  endtask

  // Full run: nf frames, optional random stalls, optional wrong core TLAST at bad_idx,
  // optional START-while-busy and EVENT_TLAST_MISSING pulses.
  task automatic run_frames(input int nf, input bit stall, input int bad_idx,
                            input bit mid_start, input bit ev_pulse,
                            input logic [2:0] exp_err, input string name);
    int total, in_sent, out_sent, cfg_hs, done_n;
    bit e, fin;
    total = nf * N; in_sent = 0; out_sent = 0; cfg_hs = 0; done_n = 0; fin = 0;
    in_q.delete(); out_q.delete();
    for (int i = 0; i < total; i++) begin
      in_q.push_back((i % N) == N - 1);
      out_q.push_back((i % N) == N - 1);
    end
    num_frames = nf[15:0]; fwd_inv = 1; scale = 10'h2AA; start = 1;
    @(posedge clk); #1;
    start = 0; num_frames = 0; fwd_inv = 0; scale = 0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      config_tready = !stall || ($urandom_range(1) == 1);
      din_tready    = !stall || ($urandom_range(1) == 1);
      s2m_tready    = !stall || ($urandom_range(1) == 1);
      m2s_tvalid    = (in_sent < total) && (!stall || ($urandom_range(1) == 1));
      dout_tvalid   = (out_sent < in_sent) && (!stall || ($urandom_range(1) == 1));
      dout_tlast    = ((out_sent % N) == N - 1) || (out_sent == bad_idx);
      start         = mid_start && cyc == 5;
      num_frames    = (mid_start && cyc == 5) ? 16'd5 : 16'd0;
      ev_miss       = ev_pulse && cyc == 6;
      @(negedge clk);
      if (cyc == 0) begin
        tests_run++;
        if (busy !== 1'b1 || err !== '0 || frame_in_cnt !== 16'd0 || frame_out_cnt !== 16'd0) begin
          tests_failed++;
          $display("FAIL %s start_state: busy=%b err=%0h fin=%0d fout=%0d required 1/0/0/0",
                   name, busy, err, frame_in_cnt, frame_out_cnt);
        end
      end
      if (config_tvalid && config_tready) begin
        cfg_hs++;
        tests_run++;
        if (config_tdata !== 16'h0555) begin
          tests_failed++;
          $display("FAIL %s config_tdata: got %h required 0555", name, config_tdata);
        end
      end
      if (m2s_tvalid && m2s_tready) begin
        tests_run++;
        if (in_q.size() == 0) begin
          tests_failed++;
          $display("FAIL %s extra_input_hs: got handshake %0d required none", name, in_sent);
        end else begin
          e = in_q.pop_front();
          if (din_tlast !== e || din_tvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s din_tlast[%0d]: got tlast=%b tvalid=%b required %b/1",
                     name, in_sent, din_tlast, din_tvalid, e);
          end
        end
        in_sent++;
      end
      if (dout_tvalid && dout_tready) begin
        tests_run++;
        if (out_q.size() == 0) begin
          tests_failed++;
          $display("FAIL %s extra_output_hs: got handshake %0d required none", name, out_sent);
        end else begin
          e = out_q.pop_front();
          if (s2m_tlast !== e || s2m_tvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s s2m_tlast[%0d]: got tlast=%b tvalid=%b required %b/1",
                     name, out_sent, s2m_tlast, s2m_tvalid, e);
          end
        end
        out_sent++;
      end
      if (done) begin
        done_n++;
        fin = 1;
        tests_run++;
        if (frame_in_cnt !== nf[15:0] || frame_out_cnt !== nf[15:0]) begin
          tests_failed++;
          $display("FAIL %s done_counts: got in=%0d out=%0d required %0d", name,
                   frame_in_cnt, frame_out_cnt, nf);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    repeat (3) begin
      @(negedge clk);
      if (done) done_n++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (done_n != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s done_pulse: got %0d pulses busy=%b required 1 pulse busy=0", name, done_n, busy);
    end
    tests_run++;
    if (err !== ERR_W'(exp_err)) begin
      tests_failed++;
      $display("FAIL %s err: got %b required %b", name, err, exp_err);
    end
    tests_run++;
    if (frame_in_cnt !== nf[15:0] || frame_out_cnt !== nf[15:0] || cfg_hs != 1 ||
        in_q.size() != 0 || out_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s final_counts: in=%0d out=%0d cfg_hs=%0d left=%0d/%0d required %0d/%0d/1/0/0",
               name, frame_in_cnt, frame_out_cnt, cfg_hs, in_q.size(), out_q.size(), nf, nf);
    end
  endtask

  task automatic test_basic();            run_frames(2, 0, -1, 0, 0, 3'b000, "basic"); endtask
  task automatic test_stall();            run_frames(2, 1, -1, 0, 0, 3'b000, "stall"); endtask
  task automatic test_tlast_mismatch();   run_frames(2, 0, 4, 0, 0, 3'b100, "tlast_mismatch"); endtask
  task automatic test_busy_start_event(); run_frames(2, 1, -1, 1, 1, 3'b010, "busy_start_event"); endtask
  task automatic test_back_to_back();     run_frames(1, 0, -1, 0, 0, 3'b000, "back_to_back"); endtask

  task automatic test_abort();
    int n;
    n = 0;
    num_frames = 2; start = 1;
    @(posedge clk); #1;
    start = 0; num_frames = 0; config_tready = 1;
    for (int cyc = 0; cyc < 200 && n < 11; cyc++) begin
      m2s_tvalid = 1; din_tready = 1;
      @(negedge clk);
      if (m2s_tvalid && m2s_tready) n++;
      @(posedge clk); #1;
    end
    m2s_tvalid = 0; abort_p = 1;
    @(negedge clk);
    tests_run++;
    if (frame_in_cnt !== 16'd1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_pre: fin=%0d busy=%b required 1/1", frame_in_cnt, busy);
    end
    @(posedge clk); #1;
    abort_p = 0; m2s_tvalid = 1; din_tready = 1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || m2s_tready !== 1'b0 || frame_in_cnt !== 16'd0 ||
        frame_out_cnt !== 16'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_post: busy=%b ready=%b fin=%0d fout=%0d done=%b required all 0",
               busy, m2s_tready, frame_in_cnt, frame_out_cnt, done);
    end
    @(posedge clk); #1;
    idle_inputs();
    run_frames(2, 0, -1, 0, 0, 3'b000, "after_abort");
  endtask

  task automatic test_zero_frames();
    num_frames = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (2) begin
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || config_tvalid !== 1'b0) begin
        tests_failed++;
        $display("FAIL zero_frames: busy=%b cfg_valid=%b required 0/0", busy, config_tvalid);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_tlast_mismatch();
    test_abort();
    test_zero_frames();
    test_busy_start_event();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
